cdb_arbiter: RTL and testbench

- Shares the two common data buses (cdb_0, cdb_1) among the six execute-stage result producers: LSQ_0, LSQ_1, Branch, ALU_0, ALU_1, Mult.
- Each cycle it grants up to two requesters and squashes results from threads flagged by mispredict_0 or mispredict_1.
- An age-based anti-starvation promotion overrides fixed priority.
- CDB outputs are registered; the block sits between the FU output latches and the ROB/RS/PRF wakeup logic.

---
 rtl/cdb_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares two common data buses among six execute-stage result
// producers. Grants up to two requesters per cycle, squashes mispredicted
// threads, promotes long-waiting requesters ahead of fixed priority, and
// registers the winning results onto cdb_0 / cdb_1.
module cdb_arbiter #(
  parameter int XLEN         = 64,
  parameter int PRN_BITS     = 6,
  parameter int ROB_BITS     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [5:0]            req_valid,
  input  logic [5:0]            req_thread,
  input  logic [6*XLEN-1:0]     req_result,
  input  logic [6*PRN_BITS-1:0] req_prn,
  input  logic [6*ROB_BITS-1:0] req_rob,
  input  logic [5:0]            req_mispredict,
  input  logic                  mispredict_0,
  input  logic                  mispredict_1,
  output logic [5:0]            grant,
  output logic [5:0]            kill,
  output logic                  cdb_0_valid,
  output logic                  cdb_0_thread,
  output logic [XLEN-1:0]       cdb_0_result,
  output logic [PRN_BITS-1:0]   cdb_0_prn,
  output logic [ROB_BITS-1:0]   cdb_0_rob,
  output logic                  cdb_0_mispredict,
  output logic                  cdb_1_valid,
  output logic                  cdb_1_thread,
  output logic [XLEN-1:0]       cdb_1_result,
  output logic [PRN_BITS-1:0]   cdb_1_prn,
  output logic [ROB_BITS-1:0]   cdb_1_rob,
  output logic                  cdb_1_mispredict
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  // Unpacked per-requester payload views
  logic [XLEN-1:0]     res_a [6];
  logic [PRN_BITS-1:0] prn_a [6];
  logic [ROB_BITS-1:0] rob_a [6];

  logic [5:0] squash;
  logic [5:0] eligible;
  logic [5:0] starved;
  logic [2:0] age_q [6];
  logic [2:0] age_d [6];

  logic       f0, f1;
  logic [2:0] i0, i1;

  logic                cdb_0_valid_d, cdb_0_valid_q;
  logic                cdb_0_thread_d, cdb_0_thread_q;
  logic [XLEN-1:0]     cdb_0_result_d, cdb_0_result_q;
  logic [PRN_BITS-1:0] cdb_0_prn_d, cdb_0_prn_q;
  logic [ROB_BITS-1:0] cdb_0_rob_d, cdb_0_rob_q;
  logic                cdb_0_mispredict_d, cdb_0_mispredict_q;
  logic                cdb_1_valid_d, cdb_1_valid_q;
  logic                cdb_1_thread_d, cdb_1_thread_q;
  logic [XLEN-1:0]     cdb_1_result_d, cdb_1_result_q;
  logic [PRN_BITS-1:0] cdb_1_prn_d, cdb_1_prn_q;
  logic [ROB_BITS-1:0] cdb_1_rob_d, cdb_1_rob_q;
  logic                cdb_1_mispredict_d, cdb_1_mispredict_q;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_req
      assign res_a[gi] = req_result[gi*XLEN +: XLEN];
      assign prn_a[gi] = req_prn[gi*PRN_BITS +: PRN_BITS];
      assign rob_a[gi] = req_rob[gi*ROB_BITS +: ROB_BITS];

      // Squash follows the requester's thread; reset masks everything so
      // grant/kill read as zero while reset is held.
      assign squash[gi]   = req_thread[gi] ? mispredict_1 : mispredict_0;
      assign kill[gi]     = reset & req_valid[gi] & squash[gi];
      assign eligible[gi] = reset & req_valid[gi] & ~squash[gi];
      assign starved[gi]  = eligible[gi] & (age_q[gi] == LIMIT);

      // Age grows only while eligible and passed over; saturates at the limit
      always_comb begin
        age_d[gi] = 3'd0;
        if (eligible[gi] && !grant[gi])
          age_d[gi] = (age_q[gi] == LIMIT) ? LIMIT : age_q[gi] + 3'd1;
      end

      // Age counter register
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) age_q[gi] <= 3'd0;
        else        age_q[gi] <= age_d[gi];
      end
    end
  endgenerate

  // Pick the first two candidates: starved in index order, then the rest
  always_comb begin
    f0 = 1'b0;
    f1 = 1'b0;
    i0 = 3'd0;
    i1 = 3'd0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) begin
        if ((p == 0) ? starved[i] : (eligible[i] & ~starved[i])) begin
          if (!f0) begin
            f0 = 1'b1;
            i0 = 3'(i);
          end else if (!f1) begin
            f1 = 1'b1;
            i1 = 3'(i);
          end
        end
      end
    end
    grant = 6'd0;
    if (f0) grant[i0] = 1'b1;
    if (f1) grant[i1] = 1'b1;
  end

  // Next broadcast contents; an empty bus carries all-zero fields
  always_comb begin
    cdb_0_valid_d      = f0;
    cdb_0_thread_d     = 1'b0;
    cdb_0_result_d     = '0;
    cdb_0_prn_d        = '0;
    cdb_0_rob_d        = '0;
    cdb_0_mispredict_d = 1'b0;
    cdb_1_valid_d      = f1;
    cdb_1_thread_d     = 1'b0;
    cdb_1_result_d     = '0;
    cdb_1_prn_d        = '0;
    cdb_1_rob_d        = '0;
    cdb_1_mispredict_d = 1'b0;
    if (f0) begin
      cdb_0_thread_d     = req_thread[i0];
      cdb_0_result_d     = res_a[i0];
      cdb_0_prn_d        = prn_a[i0];
      cdb_0_rob_d        = rob_a[i0];
      cdb_0_mispredict_d = req_mispredict[i0];
    end
    if (f1) begin
      cdb_1_thread_d     = req_thread[i1];
      cdb_1_result_d     = res_a[i1];
      cdb_1_prn_d        = prn_a[i1];
      cdb_1_rob_d        = rob_a[i1];
      cdb_1_mispredict_d = req_mispredict[i1];
    end
  end

  // Broadcast registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_0_valid_q      <= 1'b0;
      cdb_0_thread_q     <= 1'b0;
      cdb_0_result_q     <= '0;
      cdb_0_prn_q        <= '0;
      cdb_0_rob_q        <= '0;
      cdb_0_mispredict_q <= 1'b0;
      cdb_1_valid_q      <= 1'b0;
      cdb_1_thread_q     <= 1'b0;
      cdb_1_result_q     <= '0;
      cdb_1_prn_q        <= '0;
      cdb_1_rob_q        <= '0;
      cdb_1_mispredict_q <= 1'b0;
    end else begin
      cdb_0_valid_q      <= cdb_0_valid_d;
      cdb_0_thread_q     <= cdb_0_thread_d;
      cdb_0_result_q     <= cdb_0_result_d;
      cdb_0_prn_q        <= cdb_0_prn_d;
      cdb_0_rob_q        <= cdb_0_rob_d;
      cdb_0_mispredict_q <= cdb_0_mispredict_d;
      cdb_1_valid_q      <= cdb_1_valid_d;
      cdb_1_thread_q     <= cdb_1_thread_d;
      cdb_1_result_q     <= cdb_1_result_d;
      cdb_1_prn_q        <= cdb_1_prn_d;
      cdb_1_rob_q        <= cdb_1_rob_d;
      cdb_1_mispredict_q <= cdb_1_mispredict_d;
    end
  end

  assign cdb_0_valid      = cdb_0_valid_q;
  assign cdb_0_thread     = cdb_0_thread_q;
  assign cdb_0_result     = cdb_0_result_q;
  assign cdb_0_prn        = cdb_0_prn_q;
  assign cdb_0_rob        = cdb_0_rob_q;
  assign cdb_0_mispredict = cdb_0_mispredict_q;
  assign cdb_1_valid      = cdb_1_valid_q;
  assign cdb_1_thread     = cdb_1_thread_q;
  assign cdb_1_result     = cdb_1_result_q;
  assign cdb_1_prn        = cdb_1_prn_q;
  assign cdb_1_rob        = cdb_1_rob_q;
  assign cdb_1_mispredict = cdb_1_mispredict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: table of single-cycle vectors plus
// hand-written drain, starvation and async-reset sequences.
module tb_cdb_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [5:0]   req_valid, req_thread, req_mispredict;
  logic [383:0] req_result;
  logic [35:0]  req_prn;
  logic [29:0]  req_rob;
  logic         mispredict_0, mispredict_1;
  logic [5:0]   grant, kill;
  logic         cdb_0_valid, cdb_0_thread, cdb_0_mispredict;
  logic [63:0]  cdb_0_result;
  logic [5:0]   cdb_0_prn;
  logic [4:0]   cdb_0_rob;
  logic         cdb_1_valid, cdb_1_thread, cdb_1_mispredict;
  logic [63:0]  cdb_1_result;
  logic [5:0]   cdb_1_prn;
  logic [4:0]   cdb_1_rob;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.XLEN(64), .PRN_BITS(6), .ROB_BITS(5), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_thread(req_thread), .req_result(req_result),
    .req_prn(req_prn), .req_rob(req_rob), .req_mispredict(req_mispredict),
    .mispredict_0(mispredict_0), .mispredict_1(mispredict_1),
    .grant(grant), .kill(kill),
    .cdb_0_valid(cdb_0_valid), .cdb_0_thread(cdb_0_thread), .cdb_0_result(cdb_0_result),
    .cdb_0_prn(cdb_0_prn), .cdb_0_rob(cdb_0_rob), .cdb_0_mispredict(cdb_0_mispredict),
    .cdb_1_valid(cdb_1_valid), .cdb_1_thread(cdb_1_thread), .cdb_1_result(cdb_1_result),
    .cdb_1_prn(cdb_1_prn), .cdb_1_rob(cdb_1_rob), .cdb_1_mispredict(cdb_1_mispredict)
  );

  typedef struct {
    logic [5:0] valid;
    logic [5:0] thread;
    logic [5:0] mpf;
    logic       mp0;
    logic       mp1;
    logic [5:0] g;
    logic [5:0] k;
    logic       v0;
    int         i0;
    logic       v1;
    int         i1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Fixed payload for table vectors: result 0x100+i, prn i+1, rob i+10
  task automatic set_fixed_payload();
    for (int i = 0; i < 6; i++) begin
      req_result[i*64 +: 64] = 64'h100 + 64'(i);
      req_prn[i*6 +: 6]      = 6'(i + 1);
      req_rob[i*5 +: 5]      = 5'(i + 10);
    end
  endtask

  // Compare one bus against the expected winner index of a table vector
  task automatic chk_bus(input string nm, input int n, input logic av, input logic at,
                         input logic [63:0] ar, input logic [5:0] ap, input logic [4:0] ab,
                         input logic am, input logic ev, input int ei, input vec_t v);
    logic [5:0] th, mf;
    th = v.thread;
    mf = v.mpf;
    chk($sformatf("%s[%0d].valid", nm, n), 64'(av), 64'(ev));
    if (ev) begin
      chk($sformatf("%s[%0d].result", nm, n), ar, 64'h100 + 64'(ei));
      chk($sformatf("%s[%0d].prn", nm, n), 64'(ap), 64'(ei + 1));
      chk($sformatf("%s[%0d].rob", nm, n), 64'(ab), 64'(ei + 10));
      chk($sformatf("%s[%0d].thread", nm, n), 64'(at), 64'(th[ei]));
      chk($sformatf("%s[%0d].mispredict", nm, n), 64'(am), 64'(mf[ei]));
    end else begin
      chk($sformatf("%s[%0d].result_zero", nm, n), ar, 64'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0; req_thread = '0; req_mispredict = '0;
    req_result = '0; req_prn = '0; req_rob = '0;
    mispredict_0 = 1'b0; mispredict_1 = 1'b0;

    //           valid      thread     mpf        mp0   mp1   grant      kill       v0    i0 v1    i1
    vecs[0] = '{6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 0, 1'b0, 0};
    vecs[1] = '{6'b100000, 6'b000000, 6'b000000, 1'b0, 1'b0, 6'b100000, 6'b000000, 1'b1, 5, 1'b0, 0};
    vecs[2] = '{6'b000011, 6'b000000, 6'b000000, 1'b0, 1'b0, 6'b000011, 6'b000000, 1'b1, 0, 1'b1, 1};
    vecs[3] = '{6'b111111, 6'b000000, 6'b000000, 1'b1, 1'b0, 6'b000000, 6'b111111, 1'b0, 0, 1'b0, 0};
    vecs[4] = '{6'b011000, 6'b010000, 6'b000000, 1'b1, 1'b0, 6'b010000, 6'b001000, 1'b1, 4, 1'b0, 0};
    vecs[5] = '{6'b111111, 6'b101010, 6'b000000, 1'b0, 1'b1, 6'b000101, 6'b101010, 1'b1, 0, 1'b1, 2};
    vecs[6] = '{6'b111111, 6'b010101, 6'b000000, 1'b1, 1'b1, 6'b000000, 6'b111111, 1'b0, 0, 1'b0, 0};
    vecs[7] = '{6'b010100, 6'b010000, 6'b000100, 1'b0, 1'b0, 6'b010100, 6'b000000, 1'b1, 2, 1'b1, 4};

    // Reset state, with a request pending to show grant is masked
    req_valid = 6'b000001;
    #12;
    chk("rst.grant", 64'(grant), 64'd0);
    chk("rst.cdb0_valid", 64'(cdb_0_valid), 64'd0);
    chk("rst.cdb1_valid", 64'(cdb_1_valid), 64'd0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle.grant", 64'(grant), 64'd0);
    chk("idle.kill", 64'(kill), 64'd0);

    // Table vectors
    set_fixed_payload();
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      req_valid = vecs[n].valid;
      req_thread = vecs[n].thread;
      req_mispredict = vecs[n].mpf;
      mispredict_0 = vecs[n].mp0;
      mispredict_1 = vecs[n].mp1;
      #1;
      chk($sformatf("vec[%0d].grant", n), 64'(grant), 64'(vecs[n].g));
      chk($sformatf("vec[%0d].kill", n), 64'(kill), 64'(vecs[n].k));
      @(posedge clock);
      #1;
      chk_bus("vec.cdb0", n, cdb_0_valid, cdb_0_thread, cdb_0_result, cdb_0_prn, cdb_0_rob,
              cdb_0_mispredict, vecs[n].v0, vecs[n].i0, vecs[n]);
      chk_bus("vec.cdb1", n, cdb_1_valid, cdb_1_thread, cdb_1_result, cdb_1_prn, cdb_1_rob,
              cdb_1_mispredict, vecs[n].v1, vecs[n].i1, vecs[n]);
    end

    // Drain: all six valid, each drops once granted
    @(negedge clock);
    mispredict_0 = 1'b0; mispredict_1 = 1'b0;
    req_thread = '0; req_mispredict = '0; req_valid = '0;
    #1;
    @(negedge clock);
    req_result[0*64 +: 64] = 64'hAAAA_BEEF_BEEF_BEEF;
    req_result[1*64 +: 64] = 64'hBBBB_BEEF_BEEF_BEEF;
    req_result[2*64 +: 64] = 64'hAAAA_AAAA_AAAA_AABA;
    req_result[3*64 +: 64] = 64'd7;
    req_result[4*64 +: 64] = 64'd1;
    req_result[5*64 +: 64] = 64'd30;
    req_valid = 6'b111111;
    #1;
    chk("drain.grant1", 64'(grant), 64'h03);
    @(negedge clock);
    chk("drain.c1_cdb0", cdb_0_result, 64'hAAAA_BEEF_BEEF_BEEF);
    chk("drain.c1_cdb1", cdb_1_result, 64'hBBBB_BEEF_BEEF_BEEF);
    req_valid = 6'b111100;
    #1;
    chk("drain.grant2", 64'(grant), 64'h0C);
    @(negedge clock);
    chk("drain.c2_cdb0", cdb_0_result, 64'hAAAA_AAAA_AAAA_AABA);
    chk("drain.c2_cdb1", cdb_1_result, 64'd7);
    req_valid = 6'b110000;
    #1;
    chk("drain.grant3", 64'(grant), 64'h30);
    @(negedge clock);
    chk("drain.c3_cdb0", cdb_0_result, 64'd1);
    chk("drain.c3_cdb1", cdb_1_result, 64'd30);
    chk("drain.c3_v1", 64'(cdb_1_valid), 64'd1);
    req_valid = '0;
    @(negedge clock);
    chk("drain.idle_v0", 64'(cdb_0_valid), 64'd0);
    chk("drain.idle_v1", 64'(cdb_1_valid), 64'd0);

    // Starvation: LSQ_0/LSQ_1 never drop; ALU_0 promoted on the fifth cycle
    req_result[0*64 +: 64] = 64'h10;
    req_result[1*64 +: 64] = 64'h11;
    req_result[3*64 +: 64] = 64'h13;
    req_valid = 6'b001011;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("starve.wait%0d", c), 64'(grant), 64'h03);
      @(negedge clock);
    end
    #1;
    chk("starve.promote", 64'(grant), 64'h09);
    @(negedge clock);
    chk("starve.cdb0", cdb_0_result, 64'h13);
    chk("starve.cdb1", cdb_1_result, 64'h10);
    #1;
    chk("starve.age_cleared", 64'(grant), 64'h03);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);

    // Async reset mid-stream; ages must restart from zero afterwards
    req_valid = 6'b001011;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("areset.pre_v0", 64'(cdb_0_valid), 64'd1);
    chk("areset.pre_v1", 64'(cdb_1_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("areset.v0", 64'(cdb_0_valid), 64'd0);
    chk("areset.v1", 64'(cdb_1_valid), 64'd0);
    chk("areset.grant", 64'(grant), 64'd0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("areset.wait%0d", c), 64'(grant), 64'h03);
      @(negedge clock);
    end
    #1;
    chk("areset.promote", 64'(grant), 64'h09);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
